// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, sample-point constants and
// the parity helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  localparam logic [3:0] SAMPLE_MID = 4'd7;
  localparam logic [3:0] SAMPLE_END = 4'd15;

  // Expected parity bit for a 7- or 8-bit payload.
  function automatic logic parity_calc(input logic [7:0] data,
                                       input logic       bit8,
                                       input logic       odd_n_even);
    logic p;
    p = ^data[6:0];
    if (bit8) p = p ^ data[7];
    return p ^ odd_n_even;
  endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Serial line front end: metastability synchroniser followed by a 3-tap
// majority vote clocked by the 16x oversampling tick.
module uart_rx_filter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic baud_en,
  input  logic rx_in,
  output logic rx_filt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             taps;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      taps   <= 3'b111;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
      if (baud_en) taps <= {taps[1:0], sync_q[SYNC_STAGES-1]};
    end
  end

  assign rx_filt = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: frames start/data/parity/stop from the filtered line
// and holds one byte with ready/parity/framing/overflow status.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int RX_LEGACY_MODE = 0,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_en,
  input  logic       rx_in,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  if (RX_LEGACY_MODE != 0) begin : g_bad_mode
    $error("uart_rx_core: RX_LEGACY_MODE is reserved and must be 0");
  end
  if (SYNC_STAGES != 2 && SYNC_STAGES != 3) begin : g_bad_sync
    $error("uart_rx_core: SYNC_STAGES must be 2 or 3");
  end

  logic rx_filt;

  uart_rx_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filter (
    .clk     (clk),
    .reset   (reset),
    .baud_en (baud_en),
    .rx_in   (rx_in),
    .rx_filt (rx_filt)
  );

  rx_state_t  state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] bitcnt, bitcnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       par_pend, par_pend_nxt;
  logic       done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      par_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bitcnt   <= bitcnt_nxt;
      shreg    <= shreg_nxt;
      par_pend <= par_pend_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bitcnt_nxt   = bitcnt;
    shreg_nxt    = shreg;
    par_pend_nxt = par_pend;
    done         = 1'b0;
    if (baud_en) begin
      cnt_nxt = cnt + 4'd1;
      case (state)
        ST_IDLE: begin
          if (!rx_filt) begin
            state_nxt = ST_START;
            cnt_nxt   = '0;
          end
        end
        ST_START: begin
          if (cnt == SAMPLE_MID) begin
            cnt_nxt = '0;
            if (!rx_filt) begin
              state_nxt    = ST_DATA;
              bitcnt_nxt   = '0;
              shreg_nxt    = '0;  // keeps bit 7 clear in 7-bit mode
              par_pend_nxt = 1'b0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (cnt == SAMPLE_END) begin
            shreg_nxt[bitcnt] = rx_filt;
            bitcnt_nxt        = bitcnt + 3'd1;
            if (bitcnt == (bit8 ? 3'd7 : 3'd6))
              state_nxt = parity_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (cnt == SAMPLE_END) begin
            par_pend_nxt = rx_filt ^ parity_calc(shreg, bit8, odd_n_even);
            state_nxt    = ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt == SAMPLE_END) begin
            done      = 1'b1;
            state_nxt = rx_filt ? ST_IDLE : ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_filt) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // A completing byte wins over a same-cycle read: it is accepted and the
  // read's overflow clear still applies.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_ready    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else if (done) begin
      if (!rx_ready || read_rx_byte) begin
        rx_data     <= shreg;
        rx_ready    <= 1'b1;
        parity_err  <= par_pend;
        framing_err <= ~rx_filt;
        overflow    <= 1'b0;
      end else begin
        overflow <= 1'b1;
      end
    end else if (read_rx_byte) begin
      rx_ready <= 1'b0;
      overflow <= 1'b0;
    end
  end

endmodule
